avst_pattern_source: RTL and testbench

- Avalon-ST video packet transmitter that drives the 24-bit sink of the video FIFO, which has ready latency 1.
- Generates test-pattern frames of WIDTH x HEIGHT pixels. Each frame is one video packet: a header beat with type 0x0, then the pixels.
- Used in place of the camera path to bring up and debug the FIFO and VIP chain.

---
 rtl/avst_video_pkg.sv | 36 +++
 rtl/avst_pattern_pixel_gen.sv | 29 ++
 rtl/avst_pattern_source.sv | 197 +++++++++++++++++++
 tb/tb_avst_pattern_source.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/avst_video_pkg.sv
// Shared definitions for the Avalon-ST video pattern source.
//   - Avalon-ST video packet type codes
//   - pattern mode encoding
//   - FSM state type
//   - helper that packs three nibbles into a control-packet beat
// Optional feature macro: AVST_PATTERN_CTRL_PKT_EN adds the control-packet states.
package avst_video_pkg;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef AVST_PATTERN_CTRL_PKT_EN
    ST_CHDR,
    ST_C0,
    ST_C1,
    ST_C2,
`endif
    ST_HDR,
    ST_PIX
  } state_e;

  // Control beats carry one nibble in the low half of each 8-bit colour symbol.
  function automatic logic [23:0] ctrl_beat(input logic [3:0] n0,
                                            input logic [3:0] n1,
                                            input logic [3:0] n2);
    return {4'h0, n2, 4'h0, n1, 4'h0, n0};
  endfunction

endpackage

// File: rtl/avst_pattern_pixel_gen.sv
// Pixel colour function for the pattern source.
// Ports:
//   mode_i   : latched pattern mode for the current frame
//   x_i, y_i : pixel coordinates
//   bar_i    : colour-bar index 0..7 (maintained by the caller's down-counter)
//   pixel_o  : {R,G,B}, purely combinational
module avst_pattern_pixel_gen
  import avst_video_pkg::*;
#(
  parameter logic [23:0] SOLID_RGB = 24'hFF00FF
) (
  input  logic [1:0]  mode_i,
  input  logic [11:0] x_i,
  input  logic [11:0] y_i,
  input  logic [2:0]  bar_i,
  output logic [23:0] pixel_o
);

  always_comb begin
    pixel_o = '0;
    case (mode_i)
      MODE_BARS:  pixel_o = {{8{bar_i[2]}}, {8{bar_i[1]}}, {8{bar_i[0]}}};
      MODE_RAMP:  pixel_o = {3{x_i[7:0]}};
      MODE_CHECK: pixel_o = {24{x_i[3] ^ y_i[3]}};
      default:    pixel_o = SOLID_RGB;
    endcase
  end

endmodule

// File: rtl/avst_pattern_source.sv
// Avalon-ST video test-pattern transmitter (ready latency 1).
// Each frame: [optional 4-beat control packet] + video header beat + WIDTH*HEIGHT pixels.
// Ports:
//   clock, reset_n                 : clock, async active-low reset
//   enable_i                       : run frames back to back while high
//   mode_i                         : 0 bars, 1 grey ramp, 2 8x8 checker, 3 solid
//   avalonst_source_ready_i        : sink ready (latency 1)
//   avalonst_source_*_o            : registered Avalon-ST source outputs
//   busy_o                         : frame in progress
//   frame_count_o                  : completed frames, wrapping
// Optional feature macro: AVST_PATTERN_CTRL_PKT_EN (control packet before each frame).
module avst_pattern_source
  import avst_video_pkg::*;
#(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter logic [23:0] SOLID_RGB = 24'hFF00FF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic [1:0]  mode_i,
  input  logic        avalonst_source_ready_i,
  output logic        avalonst_source_valid_o,
  output logic [23:0] avalonst_source_data_o,
  output logic        avalonst_source_startofpacket_o,
  output logic        avalonst_source_endofpacket_o,
  output logic [1:0]  avalonst_source_empty_o,
  output logic        busy_o,
  output logic [15:0] frame_count_o
);

  localparam logic [11:0] X_LAST   = 12'(WIDTH - 1);
  localparam logic [11:0] Y_LAST   = 12'(HEIGHT - 1);
  localparam logic [8:0]  BAR_LAST = 9'(WIDTH / 8 - 1);
`ifdef AVST_PATTERN_CTRL_PKT_EN
  localparam logic [15:0] W16 = 16'(WIDTH);
  localparam logic [15:0] H16 = 16'(HEIGHT);
  localparam state_e      ST_FIRST = ST_CHDR;
`else
  localparam state_e      ST_FIRST = ST_HDR;
`endif

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [2:0]  bar_q, bar_d;
  logic [8:0]  barcnt_q, barcnt_d;
  logic [15:0] frame_q, frame_d;
  logic        busy_q, busy_d;
  logic        ready_d1_q;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [23:0] data_q, data_d;
  logic [23:0] pixel;
  logic        go;

  avst_pattern_pixel_gen #(.SOLID_RGB(SOLID_RGB)) u_pix (
    .mode_i  (mode_q),
    .x_i     (x_q),
    .y_i     (y_q),
    .bar_i   (bar_q),
    .pixel_o (pixel)
  );

  // Outputs are registered, so the beat shown while ready_d1 is high must be
  // decided on the edge that loads ready_d1: i.e. from the live ready input.
  assign go = avalonst_source_ready_i;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    x_d      = x_q;
    y_d      = y_q;
    bar_d    = bar_q;
    barcnt_d = barcnt_q;
    frame_d  = frame_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          mode_d  = mode_i;
          busy_d  = 1'b1;
          state_d = ST_FIRST;
        end else begin
          busy_d  = 1'b0;
        end
      end
`ifdef AVST_PATTERN_CTRL_PKT_EN
      ST_CHDR: if (go) begin
        valid_d = 1'b1;
        sop_d   = 1'b1;
        data_d  = {20'h0, PKT_CTRL};
        state_d = ST_C0;
      end
      ST_C0: if (go) begin
        valid_d = 1'b1;
        data_d  = ctrl_beat(W16[15:12], W16[11:8], W16[7:4]);
        state_d = ST_C1;
      end
      ST_C1: if (go) begin
        valid_d = 1'b1;
        data_d  = ctrl_beat(W16[3:0], H16[15:12], H16[11:8]);
        state_d = ST_C2;
      end
      ST_C2: if (go) begin
        valid_d = 1'b1;
        eop_d   = 1'b1;
        data_d  = ctrl_beat(H16[7:4], H16[3:0], 4'h3);
        state_d = ST_HDR;
      end
`endif
      ST_HDR: if (go) begin
        valid_d = 1'b1;
        sop_d   = 1'b1;
        data_d  = {20'h0, PKT_VIDEO};
        state_d = ST_PIX;
      end
      ST_PIX: if (go) begin
        valid_d = 1'b1;
        data_d  = pixel;
        if (x_q == X_LAST) begin
          // line wrap also restarts the bar sequence
          x_d      = '0;
          bar_d    = '0;
          barcnt_d = BAR_LAST;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            eop_d   = 1'b1;
            frame_d = frame_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            y_d = y_q + 12'd1;
          end
        end else begin
          x_d = x_q + 12'd1;
          // down-counter of pixels left in the current bar
          if (barcnt_q == '0) begin
            barcnt_d = BAR_LAST;
            bar_d    = bar_q + 3'd1;
          end else begin
            barcnt_d = barcnt_q - 9'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      bar_q      <= '0;
      barcnt_q   <= BAR_LAST;  // reload value, so the first bar is full width
      frame_q    <= '0;
      busy_q     <= 1'b0;
      ready_d1_q <= 1'b0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      bar_q      <= bar_d;
      barcnt_q   <= barcnt_d;
      frame_q    <= frame_d;
      busy_q     <= busy_d;
      ready_d1_q <= avalonst_source_ready_i;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      data_q     <= data_d;
    end
  end

  // A beat is only ever presented in a cycle the sink has granted.
  a_valid_in_grant: assert property (@(posedge clock) disable iff (!reset_n)
    valid_q |-> ready_d1_q);

  assign avalonst_source_valid_o         = valid_q;
  assign avalonst_source_data_o          = data_q;
  assign avalonst_source_startofpacket_o = sop_q;
  assign avalonst_source_endofpacket_o   = eop_q;
  assign avalonst_source_empty_o         = 2'b00;
  assign busy_o                          = busy_q;
  assign frame_count_o                   = frame_q;

endmodule

// File: tb/tb_avst_pattern_source.sv
module tb_avst_pattern_source;

  localparam int          W     = 16;
  localparam int          H     = 2;
  localparam logic [23:0] SOLID = 24'h12AB34;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        ready = 1'b1;
  logic        valid, sop, eop, busy;
  logic [23:0] data;
  logic [1:0]  empty;
  logic [15:0] fcnt;

  avst_pattern_source #(.WIDTH(W), .HEIGHT(H), .SOLID_RGB(SOLID)) dut (
    .clock                           (clock),
    .reset_n                         (reset_n),
    .enable_i                        (enable),
    .mode_i                          (mode),
    .avalonst_source_ready_i         (ready),
    .avalonst_source_valid_o         (valid),
    .avalonst_source_data_o          (data),
    .avalonst_source_startofpacket_o (sop),
    .avalonst_source_endofpacket_o   (eop),
    .avalonst_source_empty_o         (empty),
    .busy_o                          (busy),
    .frame_count_o                   (fcnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [23:0] d; logic s; logic e;} beat_t;
  beat_t sb[$];
  int n_cmp = 0, n_err = 0, beats = 0, eops = 0;
  int ready_pat = 0;  // 0: held high, 1: toggling
  logic ready_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic s, input logic e);
    beat_t b;
    b.d = d; b.s = s; b.e = e;
    sb.push_back(b);
  endtask

  function automatic logic [23:0] pix(input int m, input int x, input int y);
    logic [2:0] b;
    case (m)
      0: begin
        b = 3'(x / (W / 8));
        return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      end
      1: return {3{8'(x)}};
      2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return SOLID;
    endcase
  endfunction

  task automatic push_frame(input int m);
`ifdef AVST_PATTERN_CTRL_PKT_EN
    // W=0x0010, H=0x0002
    push(24'h00000F, 1'b1, 1'b0);
    push(24'h010000, 1'b0, 1'b0);
    push(24'h000000, 1'b0, 1'b0);
    push(24'h030200, 1'b0, 1'b1);
`endif
    push(24'h000000, 1'b1, 1'b0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        push(pix(m, x, y), 1'b0, (x == W - 1) && (y == H - 1));
  endtask

  // model of the sink-side ready_d1
  always @(posedge clock or negedge reset_n)
    if (!reset_n) ready_prev <= 1'b0;
    else          ready_prev <= ready;

  initial forever begin
    @(posedge clock);
    #1;
    if (ready_pat == 1) ready = ~ready;
    else                ready = 1'b1;
  end

  // monitor / scoreboard
  initial begin
    beat_t e;
    forever begin
      @(negedge clock);
      if (valid === 1'b1) begin
        check("valid_needs_ready_d1", 32'(ready_prev), 32'd1);
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got %06h expected none", data);
        end else begin
          e = sb.pop_front();
          check("beat{data,sop,eop}", {6'b0, data, sop, eop}, {6'b0, e.d, e.s, e.e});
        end
        beats++;
        if (eop === 1'b1) eops++;
      end
    end
  end

  task automatic wait_eops(input int target, input int budget);
    int n = 0;
    while (eops < target && n < budget) begin @(negedge clock); n++; end
    if (eops < target) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_eop: got %0d expected %0d", eops, target);
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin @(negedge clock); n++; end
    if (beats < target) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_beat: got %0d expected %0d", beats, target);
    end
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {valid, sop, eop, data, busy, empty},
          {1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 2'b00});
    check("reset_frame_count", 32'(fcnt), 32'd0);
    reset_n = 1'b1;

    // bars, ready held high, single enable pulse
    @(posedge clock); #1;
    push_frame(0);
    enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    wait_eops(1, 200);
    repeat (3) @(negedge clock);
    check("t1_frame_count", 32'(fcnt), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // bars again with ready toggling
    ready_pat = 1;
    push_frame(0);
    @(posedge clock); #1;
    enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    wait_eops(2, 400);
    ready_pat = 0;
    repeat (4) @(negedge clock);
    check("t2_frame_count", 32'(fcnt), 32'd2);

    // ramp, mode switched mid-frame; enable dropped during beat 10 of next frame
    @(posedge clock); #1;
    mode = 2'd1;
    push_frame(1);
    push_frame(2);
    enable = 1'b1;
    base = beats;
    wait_beats(base + 5, 100);
    mode = 2'd2;
    wait_eops(3, 200);
    base = beats;
    wait_beats(base + 10, 100);
    enable = 1'b0;
    wait_eops(4, 200);
    repeat (10) @(negedge clock);
    check("t3_idle_busy_valid", {30'b0, busy, valid}, 32'd0);
    check("t3_frame_count", 32'(fcnt), 32'd4);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // async reset in the middle of a frame
    @(posedge clock); #1;
    mode = 2'd3;
    push_frame(3);
    enable = 1'b1;
    base = beats;
    wait_beats(base + 5, 100);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_reset_vse", {29'b0, valid, sop, eop}, 32'd0);
    check("t4_reset_frame_count", 32'(fcnt), 32'd0);
    sb.delete();
    push_frame(3);
    @(negedge clock);
    reset_n = 1'b1;
    base = beats;
    wait_beats(base + 2, 100);
    enable = 1'b0;
    wait_eops(eops + 1, 200);
    repeat (10) @(negedge clock);
    check("t4_frame_count", 32'(fcnt), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
